key_debounce: RTL
=================

Name: key_debounce

Overview:
- Multi-key debouncer sitting directly downstream of the board clock divider that produces the ~50 Hz sample square wave.
- Samples raw push-button inputs only on rising edges of that slow wave, detected inside the clk domain; the slow wave is never used as a clock.
- Emits clean key levels plus one-clk-cycle press/release pulses for the CPU board I/O logic.

Parameters:
- N_KEYS, 4: number of independent keys.
- STABLE_CNT, 3: consecutive agreeing samples needed to accept a change; legal range 2..15.
- ACTIVE_LOW, 1: 1 = key_raw reads 0 when pressed (pull-up board); 0 = active-high.
- REPEAT_DELAY, 25: samples held before the first auto-repeat (macro builds only).
- REPEAT_RATE, 5: samples between subsequent repeats (macro builds only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- slow_clk  in  1  divider square-wave output, clk-domain level.
- key_raw  in  N_KEYS  raw asynchronous button pins.
- key_level  out  N_KEYS  debounced state, 1 = pressed, registered.
- key_press  out  N_KEYS  1-cycle pulse on accepted press.
- key_release  out  N_KEYS  1-cycle pulse on accepted release.
- key_repeat  out  N_KEYS  1-cycle auto-repeat pulse; constant 0 without the macro.

Behaviour:
- Reset and synchronisers:
  - key_raw passes through 2-FF synchronisers. On reset they load the released value: 1 if ACTIVE_LOW, else 0.
  - slow_clk passes through a 2-FF synchroniser plus a delay reg, all reset to 1. This suppresses a spurious tick right after reset.
- tick = sync_slow & ~slow_d, which is high for exactly one clk per slow_clk rising edge.
- pressed[i] = synchronised key XOR ACTIVE_LOW.
- Per-key FSM and counter (width 4) change only on tick cycles. In non-tick cycles the state is held and all pulses are 0.
  - IDLE: pressed -> PRESS_CHK, cnt=1. Otherwise stay.
  - PRESS_CHK: not pressed -> IDLE, cnt=0. cnt+1==STABLE_CNT -> HELD, cnt=0, key_press pulse. Else cnt++.
  - HELD: not pressed -> REL_CHK, cnt=1. Otherwise stay.
  - REL_CHK: pressed -> HELD, cnt=0, no pulse. cnt+1==STABLE_CNT -> IDLE, key_release pulse. Else cnt++.
- key_level = 1 in HELD and REL_CHK.
- Outputs are registered. Pulses and the key_level change appear on the clk edge that ends the tick cycle. Total latency from a clean edge is STABLE_CNT ticks plus 3 clk cycles.
- A glitch shorter than STABLE_CNT samples never produces a pulse.
- Keys are fully independent; simultaneous presses give simultaneous pulses.
- rst asserted mid-debounce: FSM to IDLE, all outputs 0 immediately, no pulse on deassertion.
- If slow_clk is stuck, no state changes occur.

Optional Feature:
- Macro KEY_DEBOUNCE_REPEAT_EN.
- Defined:
  - A per-key repeat counter (width 8) is cleared on entry to HELD and counts ticks while in HELD.
  - The first key_repeat pulse fires at count REPEAT_DELAY. Later pulses fire every REPEAT_RATE ticks after that.
  - The counter freezes in REL_CHK and is cleared on return to IDLE. Returning from REL_CHK to HELD resumes the count, it does not restart.
- Undefined: key_repeat tied to 0 and no repeat registers exist.

Decomposition:
- Shared package key_pkg holds:
  - state encoding typedef: IDLE=0, PRESS_CHK=1, HELD=2, REL_CHK=3;
  - counter width constant CNT_W=4;
  - repeat counter width RPT_W=8.
- One sub-module, key_debounce_ch: a single-key FSM with counters and optional repeat.
- The top holds the synchronisers and tick logic and instantiates N_KEYS channels in a generate loop.

Test Plan:
- Reset and clean press: ACTIVE_LOW=1, STABLE_CNT=3, slow_clk period 20 clk. Key 0 is driven low and held -> key_press[0] pulses once, 1 clk wide, on the 3rd tick after the synchronised low; key_level[0]=1.
- Bounce rejection: key 1 toggles every 7 clk for 60 clk, then settles high (released) -> no press or release pulse; key_level[1] stays 0.
- Release with mid-bounce: from HELD, key goes high for 1 tick, low for 1 tick, then high -> no pulse on the first blip; key_release pulses after 3 stable high ticks.
- Simultaneous keys: keys 0 and 3 pressed on the same cycle -> key_press=4'b1001 in a single cycle.
- Reset mid-operation: rst asserted while key 2 is in PRESS_CHK with cnt=2 -> all outputs 0 at once. After rst release with the key still pressed, a full 3 ticks elapse before key_press[2].
- Repeat (macro on): REPEAT_DELAY=4, REPEAT_RATE=2, key held 10 ticks -> key_repeat pulses at HELD ticks 4, 6, 8, 10. With the macro off, key_repeat is always 0.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debouncer: channel state encoding and counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_pkg;

  localparam int CNT_W = 4;
  localparam int RPT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_e;

  // The debounced level is "pressed" while held or while a release is still unconfirmed.
  function automatic logic is_down(state_e s);
    return (s == HELD) || (s == REL_CHK);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single-key debounce FSM; advances only on sample ticks, optional auto-repeat (KEY_DEBOUNCE_REPEAT_EN).
// Latency: level and pulses register on the clk edge that ends the accepting tick cycle.
// Backpressure: none; pulses are one clk wide and are not held.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int STABLE_CNT = 3
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 5
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pressed,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Next-state: only tick cycles may move the FSM; pulses default low otherwise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_inc   = cnt_q + 1'b1;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (pressed) begin
            state_d = PRESS_CHK;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_CHK: begin
          if (!pressed) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == STABLE_V) begin
            state_d = HELD;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (!pressed) begin
            state_d = REL_CHK;
            cnt_d   = CNT_W'(1);
          end
        end
        REL_CHK: begin
          if (pressed) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_inc == STABLE_V) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    level_d = is_down(state_d);
  end

  // State, counter and registered outputs; reset forces everything quiet at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [RPT_W-1:0] DELAY_V = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] WRAP_V  = RPT_W'(REPEAT_DELAY + REPEAT_RATE);

  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             rep_q, rep_d;

  // Repeat count: runs on held ticks, freezes in REL_CHK, and after the first repeat
  // folds back to DELAY so each later repeat lands RATE ticks after the previous one.
  always_comb begin
    rpt_d   = rpt_q;
    rep_d   = 1'b0;
    rpt_inc = rpt_q + 1'b1;
    if (tick) begin
      if (state_q == HELD && pressed) begin
        if (rpt_inc == DELAY_V) begin
          rep_d = 1'b1;
          rpt_d = rpt_inc;
        end else if (rpt_inc == WRAP_V) begin
          rep_d = 1'b1;
          rpt_d = DELAY_V;
        end else begin
          rpt_d = rpt_inc;
        end
      end else if (state_d == IDLE || (state_q == PRESS_CHK && state_d == HELD)) begin
        rpt_d = '0;
      end
    end
  end

  // Repeat counter and registered repeat pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
      rep_q <= rep_d;
    end
  end

  assign key_repeat = rep_q;
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: syncs raw keys and the slow sample wave, turns its rising edges into ticks (KEY_DEBOUNCE_REPEAT_EN adds auto-repeat).
// Latency: STABLE_CNT ticks plus 3 clk from a clean key edge to level/pulse.
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int STABLE_CNT = 3,
  parameter int ACTIVE_LOW = 1
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 5
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slow_clk,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  // Pin value of a released key on this board.
  localparam logic REL_VAL = (ACTIVE_LOW != 0);

  logic [N_KEYS-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic              slow_s1_q, slow_s1_d, slow_s2_q, slow_s2_d, slow_dly_q, slow_dly_d;
  logic              tick;
  logic [N_KEYS-1:0] pressed;

  // Synchroniser and edge-delay inputs.
  always_comb begin
    key_s1_d   = key_raw;
    key_s2_d   = key_s1_q;
    slow_s1_d  = slow_clk;
    slow_s2_d  = slow_s1_q;
    slow_dly_d = slow_s2_q;
  end

  // Keys reset to "released"; slow wave resets high so no tick fires straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1_q   <= {N_KEYS{REL_VAL}};
      key_s2_q   <= {N_KEYS{REL_VAL}};
      slow_s1_q  <= 1'b1;
      slow_s2_q  <= 1'b1;
      slow_dly_q <= 1'b1;
    end else begin
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      slow_s1_q  <= slow_s1_d;
      slow_s2_q  <= slow_s2_d;
      slow_dly_q <= slow_dly_d;
    end
  end

  assign tick    = slow_s2_q & ~slow_dly_q;
  assign pressed = key_s2_q ^ {N_KEYS{REL_VAL}};

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .STABLE_CNT(STABLE_CNT)
`ifdef KEY_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .pressed    (pressed[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_repeat (key_repeat[g])
    );
  end

endmodule
